// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control unit: opcodes, ALU selects, FSM states
// and the bundle of datapath control outputs.
package cpu_pkg;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'h0;
  localparam logic [2:0] ALU_ADD  = 3'h1;
  localparam logic [2:0] ALU_SUB  = 3'h2;
  localparam logic [2:0] ALU_INC  = 3'h7;

  localparam logic RF_SEL_DMEM = 1'b1;
  localparam logic RF_SEL_ALU  = 1'b0;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    LATCH  = 4'd2,
    DECODE = 4'd3,
    NOOP   = 4'd4,
    STORE  = 4'd5,
    LOAD_A = 4'd6,
    LOAD_B = 4'd7,
    ADD    = 4'd8,
    SUB    = 4'd9,
    HALT   = 4'd10
  } state_t;

  typedef struct packed {
    logic       im_rd;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra_addr;
    logic [3:0] rf_rb_addr;
    logic [2:0] alu_s0;
    logic       halted;
  } ctrl_t;

  // Undefined opcodes fall through to NOOP.
  function automatic state_t decode_op(input logic [3:0] op);
    case (op)
      OP_NOOP:  return NOOP;
      OP_STORE: return STORE;
      OP_LOAD:  return LOAD_A;
      OP_ADD:   return ADD;
      OP_SUB:   return SUB;
      OP_HALT:  return HALT;
      default:  return NOOP;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-ROM and datapath control bundle between the control unit and the
// ROM / register file / data memory it sequences.
interface control_unit_if #(
  parameter int PC_WIDTH = 7,
  parameter int IR_WIDTH = 16
);
  logic [IR_WIDTH-1:0] IR_in;
  logic [PC_WIDTH-1:0] PC_Addr;
  logic                IM_Rd;
  logic [7:0]          D_Addr;
  logic                D_Wr;
  logic                RF_s;
  logic [3:0]          RF_W_Addr;
  logic                RF_W_en;
  logic [3:0]          RF_Ra_Addr;
  logic [3:0]          RF_Rb_Addr;
  logic [2:0]          ALU_s0;
  logic [3:0]          State_out;
  logic                Halted;

  modport master (
    input  IR_in,
    output PC_Addr, IM_Rd, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State_out, Halted
  );

  modport slave (
    output IR_in,
    input  PC_Addr, IM_Rd, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State_out, Halted
  );
endinterface

// File: rtl/control_unit_pc_ir_regs.sv
// Program counter and instruction register; PC wraps modulo 2**PC_WIDTH.
module pc_ir_regs #(
  parameter int PC_WIDTH = 7,
  parameter int IR_WIDTH = 16
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                pc_inc,
  input  logic                ir_load,
  input  logic [IR_WIDTH-1:0] ir_d,
  output logic [PC_WIDTH-1:0] pc,
  output logic [IR_WIDTH-1:0] ir
);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (pc_inc)  pc <= pc + PC_WIDTH'(1);
      if (ir_load) ir <= ir_d;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetches from a synchronous ROM and drives the datapath
// controls as a Moore decode of the current state and instruction register.
//
// state  | meaning                     state  | meaning
// INIT   | post-reset idle             STORE  | RF[Ra] -> M[addr]
// FETCH  | ROM read at PC              LOAD_A | present addr, wait for q
// LATCH  | IR <= ROM q, PC++           LOAD_B | RF[Rd] <= M[addr]
// DECODE | branch on opcode            ADD    | RF[Rd] <= RF[Ra] + RF[Rb]
// NOOP   | no operation                SUB    | RF[Rd] <= RF[Ra] - RF[Rb]
// HALT   | parked until reset
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 7,
  parameter int IR_WIDTH = 16
) (
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  state_t              state;
  state_t              state_nxt;
  ctrl_t               ctrl;
  logic                pc_inc;
  logic                ir_load;
  logic [PC_WIDTH-1:0] pc;
  logic [IR_WIDTH-1:0] ir;

  logic [3:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rd;
  logic [7:0] st_addr;
  logic [7:0] ld_addr;

  assign op      = ir[15:12];
  assign ra      = ir[11:8];
  assign rb      = ir[7:4];
  assign rd      = ir[3:0];
  assign st_addr = ir[7:0];
  assign ld_addr = ir[11:4];

  pc_ir_regs #(
    .PC_WIDTH(PC_WIDTH),
    .IR_WIDTH(IR_WIDTH)
  ) u_regs (
    .clk_sys(Clock),
    .rst    (Reset),
    .pc_inc (pc_inc),
    .ir_load(ir_load),
    .ir_d   (bus.IR_in),
    .pc     (pc),
    .ir     (ir)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ctrl        = '0;
    ctrl.alu_s0 = ALU_PASS;
    pc_inc      = 1'b0;
    ir_load     = 1'b0;
    case (state)
      INIT:   state_nxt = FETCH;
      FETCH: begin
        ctrl.im_rd = 1'b1;
        state_nxt  = LATCH;
      end
      LATCH: begin
        ir_load   = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: state_nxt = decode_op(op);
      NOOP:   state_nxt = FETCH;
      STORE: begin
        ctrl.d_addr     = st_addr;
        ctrl.rf_ra_addr = ra;
        ctrl.d_wr       = 1'b1;
        state_nxt       = FETCH;
      end
      // Data memory q is registered on this edge; the write happens in LOAD_B.
      LOAD_A: begin
        ctrl.d_addr = ld_addr;
        state_nxt   = LOAD_B;
      end
      LOAD_B: begin
        ctrl.d_addr    = ld_addr;
        ctrl.rf_s      = RF_SEL_DMEM;
        ctrl.rf_w_addr = rd;
        ctrl.rf_w_en   = 1'b1;
        state_nxt      = FETCH;
      end
      ADD, SUB: begin
        ctrl.rf_ra_addr = ra;
        ctrl.rf_rb_addr = rb;
        ctrl.alu_s0     = (state == ADD) ? ALU_ADD : ALU_SUB;
        ctrl.rf_s       = RF_SEL_ALU;
        ctrl.rf_w_addr  = rd;
        ctrl.rf_w_en    = 1'b1;
        state_nxt       = FETCH;
      end
      HALT: begin
        ctrl.halted = 1'b1;
        state_nxt   = HALT;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign bus.PC_Addr    = pc;
  assign bus.IM_Rd      = ctrl.im_rd;
  assign bus.D_Addr     = ctrl.d_addr;
  assign bus.D_Wr       = ctrl.d_wr;
  assign bus.RF_s       = ctrl.rf_s;
  assign bus.RF_W_Addr  = ctrl.rf_w_addr;
  assign bus.RF_W_en    = ctrl.rf_w_en;
  assign bus.RF_Ra_Addr = ctrl.rf_ra_addr;
  assign bus.RF_Rb_Addr = ctrl.rf_rb_addr;
  assign bus.ALU_s0     = ctrl.alu_s0;
  assign bus.State_out  = state;
  assign bus.Halted     = ctrl.halted;

endmodule
